// File: rtl/fibonacci_gen_p.sv
// Sequential Fibonacci generator: F(n) mod 2^RES_W with sticky overflow,
// optional streaming of every intermediate term, and an abort control.
module fibonacci_gen_p #(
    parameter int IDX_W = 5,
    parameter int RES_W = 20
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             mode_i,
    input  logic [IDX_W-1:0] i_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_tick_o,
    output logic [RES_W-1:0] f_o,
    output logic             ovf_o,
    output logic             valid_o,
    output logic [RES_W-1:0] term_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [1:0]       state_o
);

    // Handshake: start_i is accepted only on an edge where ready_o=1 (IDLE);
    // busy_o covers OP and DONE; done_tick_o marks the single DONE cycle, when
    // f_o/ovf_o hold the result. valid_o strobes each streamed term for one cycle.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] n_q;
    logic [IDX_W-1:0] k_q;
    logic [RES_W-1:0] t0_q;
    logic [RES_W-1:0] t1_q;
    logic             mode_q;
    logic [RES_W-1:0] f_q;
    logic             ovf_q;
    logic             valid_q;
    logic [RES_W-1:0] term_q;
    logic [IDX_W-1:0] idx_q;

    logic [RES_W:0]   sum;
    logic             last;

    assign sum  = {1'b0, t0_q} + {1'b0, t1_q};
    // The counter stops at 1, so the maximum index never wraps it.
    assign last = (n_q <= IDX_W'(1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort takes priority over completion in OP
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_OP;
            end
            S_OP: begin
                if (abort_i)   state_d = S_IDLE;
                else if (last) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        ready_o     = 1'b0;
        busy_o      = 1'b0;
        done_tick_o = 1'b0;
        case (state_q)
            S_IDLE: ready_o = 1'b1;
            S_OP:   busy_o  = 1'b1;
            S_DONE: begin
                busy_o      = 1'b1;
                done_tick_o = 1'b1;
            end
            default: ready_o = 1'b0;
        endcase
    end

    // Datapath: operands, counters, result and stream registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q     <= '0;
            k_q     <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            mode_q  <= 1'b0;
            f_q     <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            term_q  <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        n_q    <= i_i;
                        mode_q <= mode_i;
                        t0_q   <= '0;
                        t1_q   <= RES_W'(1);
                        k_q    <= IDX_W'(1);
                        ovf_q  <= 1'b0;
                    end
                end
                S_OP: begin
                    if (!abort_i) begin
                        if (last) begin
                            f_q <= (n_q == '0) ? '0 : t1_q;
                        end else begin
                            t0_q <= t1_q;
                            t1_q <= sum[RES_W-1:0];
                            n_q  <= n_q - IDX_W'(1);
                            k_q  <= k_q + IDX_W'(1);
                            if (sum[RES_W]) ovf_q <= 1'b1;
                            if (mode_q) begin
                                valid_q <= 1'b1;
                                term_q  <= sum[RES_W-1:0];
                                idx_q   <= k_q + IDX_W'(1);
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign f_o     = f_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;
    assign term_o  = term_q;
    assign idx_o   = idx_q;
    assign state_o = state_q;

    ready_busy_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ready_o != busy_o);
    valid_only_streaming: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_o |-> (state_q == S_OP && mode_q));

endmodule

// File: tb/tb_fibonacci_gen_p.sv
// Directed bench for fibonacci_gen_p with hand-computed expected values
// and a queue-based scoreboard for streamed terms.
module tb_fibonacci_gen_p;

    localparam int IDX_W = 5;
    localparam int RES_W = 20;

    logic             clk_i;
    logic             rst_ni;
    logic             start_i;
    logic             abort_i;
    logic             mode_i;
    logic [IDX_W-1:0] i_i;
    logic             ready_o;
    logic             busy_o;
    logic             done_tick_o;
    logic [RES_W-1:0] f_o;
    logic             ovf_o;
    logic             valid_o;
    logic [RES_W-1:0] term_o;
    logic [IDX_W-1:0] idx_o;
    logic [1:0]       state_o;

    int n_total = 0;
    int n_bad   = 0;

    // Expected stream entries packed as {idx, term}
    logic [IDX_W+RES_W-1:0] exp_q[$];

    fibonacci_gen_p #(.IDX_W(IDX_W), .RES_W(RES_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .mode_i      (mode_i),
        .i_i         (i_i),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .done_tick_o (done_tick_o),
        .f_o         (f_o),
        .ovf_o       (ovf_o),
        .valid_o     (valid_o),
        .term_o      (term_o),
        .idx_o       (idx_o),
        .state_o     (state_o)
    );

    // Clock and reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [IDX_W+RES_W-1:0] pack(input int idx, input int term);
        logic [IDX_W-1:0] i5;
        logic [RES_W-1:0] t20;
        i5  = IDX_W'(idx);
        t20 = RES_W'(term);
        return {i5, t20};
    endfunction

    // One full run. Edges are counted with the start-accepting edge as 1.
    // abort_at/start_at: raise abort_i / a stray start (i=3) during that OP
    // cycle (0 = never).
    task automatic run(input int n, input bit md, input int abort_at, input int start_at,
                       input int exp_f, input bit exp_ovf);
        int  c;
        int  vcnt;
        bit  seen;
        int  want_lat;
        int  want_v;
        logic [IDX_W+RES_W-1:0] e;
        @(negedge clk_i);
        chk("ready_idle", ready_o, 1);
        start_i = 1'b1;
        i_i     = IDX_W'(n);
        mode_i  = md;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        i_i     = IDX_W'($urandom_range(0, 31));
        mode_i  = 1'($urandom_range(0, 1));
        c    = 1;
        vcnt = 0;
        seen = 1'b0;
        chk("ready_low_busy", {ready_o, busy_o}, 2'b01);
        if (abort_at == c) abort_i = 1'b1;
        while (!seen && c < 80) begin
            @(posedge clk_i);
            c++;
            #1;
            abort_i = (abort_at != 0 && c == abort_at);
            if (start_at != 0 && c == start_at) begin
                start_i = 1'b1;
                i_i     = IDX_W'(3);
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            if (valid_o) begin
                vcnt++;
                if (exp_q.size() == 0) begin
                    chk("stream_extra", {idx_o, term_o}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_term", {idx_o, term_o}, e);
                end
            end
            if (done_tick_o) seen = 1'b1;
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        want_lat = ((n > 1) ? n : 1) + 1;
        want_v   = (md && n > 1) ? n - 1 : 0;
        if (abort_at == 0) begin
            chk("done_seen", seen, 1);
            chk("latency", c, want_lat);
            chk("valid_count", vcnt, want_v);
            chk("f_o", f_o, exp_f);
            chk("ovf_o", ovf_o, exp_ovf);
            chk("stream_left", exp_q.size(), 0);
            @(negedge clk_i);
            chk("done_one_cycle", done_tick_o, 0);
            chk("back_idle", ready_o, 1);
        end else begin
            chk("abort_no_done", seen, 0);
            chk("abort_idle", ready_o, 1);
            chk("abort_f_kept", f_o, exp_f);
            chk("abort_ovf_kept", ovf_o, exp_ovf);
        end
        exp_q.delete();
    endtask

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        mode_i  = 1'b0;
        i_i     = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ready", ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_tick_o, 0);
        chk("rst_f", f_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_term", term_o, 0);
        chk("rst_idx", idx_o, 0);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);

        run(0, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 1, 0);
        run(10, 0, 0, 0, 55, 0);

        exp_q.push_back(pack(2, 1));
        exp_q.push_back(pack(3, 2));
        exp_q.push_back(pack(4, 3));
        exp_q.push_back(pack(5, 5));
        exp_q.push_back(pack(6, 8));
        run(6, 1, 0, 0, 8, 0);
        exp_q.push_back(pack(2, 1));
        run(2, 1, 0, 0, 1, 0);
        run(1, 1, 0, 0, 1, 0);

        run(30, 0, 0, 0, 832040, 0);
        run(31, 0, 0, 0, 297693, 1);
        run(5, 0, 0, 0, 5, 0);

        run(20, 0, 0, 3, 6765, 0);
        run(20, 0, 5, 0, 6765, 0);

        // Asynchronous reset in the middle of a streaming run
        @(negedge clk_i);
        start_i = 1'b1;
        i_i     = IDX_W'(25);
        mode_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #2;
        chk("pre_rst_valid", valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_ready", ready_o, 1);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_f", f_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_term", term_o, 0);
        chk("mid_rst_done", done_tick_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        run(7, 0, 0, 0, 13, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
